// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard: shadow-pipe entry, drain FSM states, and the
// forwarding select value that means "take the operand from the register file".
package pipe_hazard_pkg;

    localparam int NUM_REGS    = 8;
    localparam int REG_W       = $clog2(NUM_REGS);
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic             valid;
        logic             regwrt;
        logic [REG_W-1:0] wr_reg;
        logic             is_load;
        logic             halt;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sb_state_e;

endpackage

// File: rtl/pipe_hazard_scoreboard_src_match.sv
// Per-source hazard matcher: compares one decode source register against the shadow stages that
// can still hit (WB excluded) and reports any hit, the youngest hit index and a load-use hit.
module sb_src_match
    import pipe_hazard_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]       i_valid,
    input  logic [N-1:0]       i_regwrt,
    input  logic [N*REG_W-1:0] i_wr_reg,
    input  logic               i_load0,
    input  logic [REG_W-1:0]   i_src,
    input  logic               i_used,
    output logic               o_any_hit,
    output logic [IDX_W-1:0]   o_hit_idx,
    output logic               o_load_hit
);

    logic [N-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N; i++) begin
            w_hit[i] = i_used & i_valid[i] & i_regwrt[i] &
                       (i_wr_reg[i*REG_W +: REG_W] == i_src);
        end
    end

    // Scan oldest to youngest so the lowest (youngest) matching index is the one left standing.
    always_comb begin
        o_any_hit = |w_hit;
        o_hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_hit_idx = IDX_W'(i);
            end
        end
    end

    assign o_load_hit = w_hit[0] & i_load0;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Decode-side hazard scoreboard: DEPTH-deep shadow pipe of in-flight writes, stall/forward decisions,
// branch-flush kill and HALT drain FSM. Forwarding is built in when PIPE_HAZARD_FWD_EN is defined.
module pipe_hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter  int DEPTH       = 3,
    parameter  int FLUSH_STAGE = 1,
    parameter  int CNT_W       = 16,
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs_a,
    input  logic             id_rs_a_used,
    input  logic [REG_W-1:0] id_rs_b,
    input  logic             id_rs_b_used,
    input  logic             id_regwrt,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             id_halt,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [SEL_W-1:0] inflight,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CHK   = DEPTH - 1;
    localparam int IDX_W = $clog2(DEPTH);

    sb_entry_t  r_stage [DEPTH];
    sb_entry_t  w_src   [CHK];
    sb_entry_t  w_id_entry;
    sb_state_e  r_state;
    sb_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_issue;
    logic             w_hazard;
    logic             w_halt_killed;
    logic             w_all_empty;
    logic [CHK-1:0]       w_chk_valid;
    logic [CHK-1:0]       w_chk_regwrt;
    logic [CHK*REG_W-1:0] w_chk_wr;
    logic             w_a_any, w_b_any, w_a_load, w_b_load;
    logic [IDX_W-1:0] w_a_idx, w_b_idx;

    always_comb begin
        w_chk_valid  = '0;
        w_chk_regwrt = '0;
        w_chk_wr     = '0;
        for (int i = 0; i < CHK; i++) begin
            w_chk_valid[i]                = r_stage[i].valid;
            w_chk_regwrt[i]               = r_stage[i].regwrt;
            w_chk_wr[i*REG_W +: REG_W]    = r_stage[i].wr_reg;
        end
    end

    sb_src_match #(.N(CHK), .IDX_W(IDX_W)) u_match_a (
        .i_valid    (w_chk_valid),
        .i_regwrt   (w_chk_regwrt),
        .i_wr_reg   (w_chk_wr),
        .i_load0    (r_stage[0].is_load),
        .i_src      (id_rs_a),
        .i_used     (id_rs_a_used),
        .o_any_hit  (w_a_any),
        .o_hit_idx  (w_a_idx),
        .o_load_hit (w_a_load)
    );

    sb_src_match #(.N(CHK), .IDX_W(IDX_W)) u_match_b (
        .i_valid    (w_chk_valid),
        .i_regwrt   (w_chk_regwrt),
        .i_wr_reg   (w_chk_wr),
        .i_load0    (r_stage[0].is_load),
        .i_src      (id_rs_b),
        .i_used     (id_rs_b_used),
        .o_any_hit  (w_b_any),
        .o_hit_idx  (w_b_idx),
        .o_load_hit (w_b_load)
    );

`ifdef PIPE_HAZARD_FWD_EN
    assign w_hazard  = w_a_load | w_b_load;
    assign fwd_a_sel = w_a_any ? SEL_W'(w_a_idx) + SEL_W'(1) : SEL_W'(FWD_REGFILE);
    assign fwd_b_sel = w_b_any ? SEL_W'(w_b_idx) + SEL_W'(1) : SEL_W'(FWD_REGFILE);
`else
    logic w_unused;
    assign w_hazard  = w_a_any | w_b_any;
    assign fwd_a_sel = SEL_W'(FWD_REGFILE);
    assign fwd_b_sel = SEL_W'(FWD_REGFILE);
    assign w_unused  = ^{w_a_idx, w_b_idx, w_a_load, w_b_load};
`endif

    assign stall   = id_valid & ~flush & (w_hazard | (r_state == DRAIN));
    assign w_issue = id_valid & ~stall & ~flush & (r_state == RUN);
    assign halted  = (r_state == HALTED);
    assign stall_cnt = r_stall_cnt;

    assign w_id_entry = '{valid: 1'b1, regwrt: id_regwrt, wr_reg: id_wr_reg,
                          is_load: id_is_load, halt: id_halt};

    // Entries younger than the resolving branch are killed before they shift on.
    always_comb begin
        w_halt_killed = 1'b0;
        for (int i = 0; i < CHK; i++) begin
            w_src[i] = r_stage[i];
            if (flush && (i < FLUSH_STAGE)) begin
                w_src[i].valid = 1'b0;
                w_halt_killed  = w_halt_killed | (r_stage[i].valid & r_stage[i].halt);
            end
        end
    end

    always_comb begin
        w_all_empty = 1'b1;
        inflight    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_all_empty = w_all_empty & ~r_stage[i].valid;
            inflight    = inflight + SEL_W'(r_stage[i].valid);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_issue && id_halt) w_state_nxt = DRAIN;
            DRAIN:   if (w_halt_killed)      w_state_nxt = RUN;
                     else if (w_all_empty)   w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            r_stage[0] <= w_issue ? w_id_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= w_src[i-1];
            end
            r_state <= w_state_nxt;
            if (stall && (r_state == RUN) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
